pipe_stall_ctrl: RTL and testbench

//  Responder side of the pipeline hazard interface. Consumes the load-use stall

---
 rtl/pipe_stall_ctrl_pkg.sv | 31 +++
 rtl/pipe_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipe_stall_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encoding,
// RUN-state action priority and the default halt-drain length.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Actions in RUN, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    ACT_FREEZE  = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_STALL   = 3'd2,
    ACT_HALT    = 3'd3,
    ACT_ADVANCE = 3'd4
  } run_act_e;

  localparam int DRAIN_CYC_DEFAULT = 3;

  function automatic run_act_e run_action(input logic mem_busy, input logic flush,
                                          input logic load_use, input logic halt_req);
    if (mem_busy)      return ACT_FREEZE;
    else if (flush)    return ACT_FLUSH;
    else if (load_use) return ACT_STALL;
    else if (halt_req) return ACT_HALT;
    else               return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline register enable/bubble generator with a registered ID/EX control
// bus and a halt-drain FSM (RUN -> DRAIN -> HALTED, left only through rst).
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W    = 16,
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadUse,
  input  logic              flushReq,
  input  logic              memBusy,
  input  logic              haltReq,
  input  logic [CTRL_W-1:0] ctrl_id,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              EX_MEM_Write,
  output logic              MEM_WB_Bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stallCount,
  output logic [CNT_W-1:0]  flushCount,
  output logic [1:0]        state
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  state_e            cur_state, next_state;
  run_act_e          act;
  logic [CTRL_W-1:0] ctrl_next;
  logic              flush_pend, pend_next;
  logic [DW-1:0]     drain_cnt, drain_next;
  logic              pc_en, ifid_en, ifid_nop, exmem_en, memwb_nop, stop;
  logic              stall_inc, flush_inc;

  assign act = run_action(memBusy, flushReq | flush_pend, loadUse, haltReq);

  always_comb begin
    next_state = cur_state;
    ctrl_next  = ctrl_ex;
    pend_next  = flush_pend;
    drain_next = drain_cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_nop   = 1'b0;
    exmem_en   = 1'b0;
    memwb_nop  = 1'b1;
    stop       = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (cur_state)
      RUN: begin
        case (act)
          ACT_FREEZE: pend_next = flush_pend | flushReq;
          ACT_FLUSH: begin
            // IF/ID stays enabled so that it actually captures the NOP.
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            ifid_nop  = 1'b1;
            exmem_en  = 1'b1;
            memwb_nop = 1'b0;
            ctrl_next = '0;
            pend_next = 1'b0;
            flush_inc = 1'b1;
          end
          ACT_STALL: begin
            exmem_en  = 1'b1;
            memwb_nop = 1'b0;
            ctrl_next = '0;
            stall_inc = 1'b1;
          end
          ACT_HALT: begin
            exmem_en   = 1'b1;
            memwb_nop  = 1'b0;
            ctrl_next  = ctrl_id;
            drain_next = DW'(DRAIN_CYC);
            next_state = DRAIN;
          end
          default: begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_nop = 1'b0;
            ctrl_next = ctrl_id;
          end
        endcase
      end
      DRAIN: begin
        if (!memBusy) begin
          exmem_en  = 1'b1;
          memwb_nop = 1'b0;
          ctrl_next = '0;
          if (drain_cnt == DW'(1)) begin
            drain_next = '0;
            next_state = HALTED;
          end else begin
            drain_next = drain_cnt - DW'(1);
          end
        end
      end
      HALTED: begin
        stop      = 1'b1;
        ctrl_next = '0;
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= RUN;
      ctrl_ex    <= '0;
      flush_pend <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      cur_state  <= next_state;
      ctrl_ex    <= ctrl_next;
      flush_pend <= pend_next;
      drain_cnt  <= drain_next;
    end
  end

  // Gate with rst so the pipe is frozen for the whole time reset is held.
  assign PCWrite       = pc_en & ~rst;
  assign IF_ID_Write   = ifid_en & ~rst;
  assign IF_ID_Flush   = ifid_nop & ~rst;
  assign EX_MEM_Write  = exmem_en & ~rst;
  assign MEM_WB_Bubble = memwb_nop | rst;
  assign halted        = stop & ~rst;
  assign state         = cur_state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .q   (flushCount)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed plus randomized bench for pipe_stall_ctrl against a behavioural
// model of the stall/flush/halt rules.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        loadUse = 1'b0, flushReq = 1'b0, memBusy = 1'b0, haltReq = 1'b0;
  logic [15:0] ctrl_id = 16'h0;
  logic [15:0] ctrl_ex;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, EX_MEM_Write, MEM_WB_Bubble, halted;
  logic [15:0] stallCount, flushCount;
  logic [1:0]  state;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: mode 0=running, 1=draining, 2=stopped.
  int          m_mode, m_drain_left, m_stall, m_flush;
  logic [15:0] m_ctrl;
  bit          m_pend;

  pipe_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .loadUse       (loadUse),
    .flushReq      (flushReq),
    .memBusy       (memBusy),
    .haltReq       (haltReq),
    .ctrl_id       (ctrl_id),
    .ctrl_ex       (ctrl_ex),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .EX_MEM_Write  (EX_MEM_Write),
    .MEM_WB_Bubble (MEM_WB_Bubble),
    .halted        (halted),
    .stallCount    (stallCount),
    .flushCount    (flushCount),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_drain_left = 0; m_stall = 0; m_flush = 0;
    m_ctrl = 16'h0; m_pend = 1'b0;
  endtask

  task automatic check_comb();
    bit run, drn, hlt, wrong_path, stall, hold;
    bit e_pc, e_iff, e_exw, e_bub, e_hlt;
    run = (m_mode == 0); drn = (m_mode == 1); hlt = (m_mode == 2);
    wrong_path = run && !memBusy && (flushReq || m_pend);
    stall = run && !memBusy && !wrong_path && loadUse;
    hold  = run && !memBusy && !wrong_path && !loadUse && haltReq;
    if (rst) begin
      e_pc = 0; e_iff = 0; e_exw = 0; e_bub = 1; e_hlt = 0;
    end else begin
      e_pc  = run && !memBusy && !stall && !hold;
      e_iff = wrong_path;
      e_exw = (run || drn) && !memBusy;
      e_bub = !e_exw;
      e_hlt = hlt;
    end
    chk("PCWrite", PCWrite, e_pc);
    chk("IF_ID_Write", IF_ID_Write, e_pc);
    chk("IF_ID_Flush", IF_ID_Flush, e_iff);
    chk("EX_MEM_Write", EX_MEM_Write, e_exw);
    chk("MEM_WB_Bubble", MEM_WB_Bubble, e_bub);
    chk("halted", halted, e_hlt);
  endtask

  task automatic check_regs();
    chk("ctrl_ex", ctrl_ex, m_ctrl);
    chk("stallCount", stallCount, m_stall[15:0]);
    chk("flushCount", flushCount, m_flush[15:0]);
    chk("state", state, m_mode[1:0]);
  endtask

  task automatic model_step();
    bit run, drn, wrong_path, stall, hold;
    run = (m_mode == 0); drn = (m_mode == 1);
    wrong_path = run && !memBusy && (flushReq || m_pend);
    stall = run && !memBusy && !wrong_path && loadUse;
    hold  = run && !memBusy && !wrong_path && !loadUse && haltReq;
    if ((run || drn) && memBusy) m_ctrl = m_ctrl;
    else if (wrong_path || stall || !run) m_ctrl = 16'h0;
    else m_ctrl = ctrl_id;
    if (run && memBusy) m_pend = m_pend || flushReq;
    else if (wrong_path) m_pend = 1'b0;
    if (stall && m_stall < 65535) m_stall++;
    if (wrong_path && m_flush < 65535) m_flush++;
    if (hold) begin
      m_mode = 1; m_drain_left = 3;
    end else if (drn && !memBusy) begin
      m_drain_left--;
      if (m_drain_left == 0) m_mode = 2;
    end
  endtask

  // Starts and ends at posedge+1.
  task automatic cycle(input bit lu, input bit fr, input bit mb, input bit hr,
                       input logic [15:0] cid);
    loadUse = lu; flushReq = fr; memBusy = mb; haltReq = hr; ctrl_id = cid;
    #3;
    check_comb();
    @(posedge clk);
    model_step();
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    loadUse = 0; flushReq = 0; memBusy = 0; haltReq = 0; ctrl_id = 16'h0;
    #2;
    m_reset();
    check_comb();
    check_regs();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    #1;
    do_reset();

    // Load-use stall bubbles one cycle, then the held instruction issues.
    cycle(1, 0, 0, 0, 16'hA5A5);
    chk("t1_stall", stallCount, 32'd1);
    cycle(0, 0, 0, 0, 16'hA5A5);
    chk("t1_ctrl", ctrl_ex, 32'hA5A5);

    // Flush beats a simultaneous load-use.
    do_reset();
    cycle(0, 0, 0, 0, 16'h1234);
    cycle(1, 1, 0, 0, 16'h5555);
    chk("t2_ctrl", ctrl_ex, 32'h0);
    chk("t2_flush", flushCount, 32'd1);
    chk("t2_stall", stallCount, 32'd0);

    // Memory busy freezes and defers a flush until it drops.
    do_reset();
    cycle(0, 0, 0, 0, 16'hBEEF);
    cycle(0, 0, 1, 0, 16'h1111);
    cycle(0, 1, 1, 0, 16'h2222);
    cycle(1, 0, 1, 0, 16'h3333);
    chk("t3_hold", ctrl_ex, 32'hBEEF);
    chk("t3_noflush", flushCount, 32'd0);
    cycle(0, 0, 0, 0, 16'h4444);
    chk("t3_flush", flushCount, 32'd1);

    // Halt: three drain cycles, then permanently stopped.
    do_reset();
    cycle(0, 0, 0, 1, 16'h0077);
    chk("t4_ctrl", ctrl_ex, 32'h0077);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 16'hFFFF);
    chk("t4_halted", halted, 32'd1);
    for (int i = 0; i < 4; i++) cycle(i[0], 1, 0, 0, 16'h1357);
    chk("t4_stay", halted, 32'd1);
    chk("t4_noflush", flushCount, 32'd0);

    // Halt with memory busy for two drain cycles delays stop by two.
    do_reset();
    cycle(0, 0, 0, 1, 16'h0088);
    cycle(0, 0, 0, 0, 16'h0);
    cycle(0, 0, 1, 0, 16'h0);
    cycle(0, 0, 1, 0, 16'h0);
    cycle(0, 0, 0, 0, 16'h0);
    chk("t4b_draining", halted, 32'd0);
    cycle(0, 0, 0, 0, 16'h0);
    chk("t4b_halted", halted, 32'd1);

    // Randomized traffic in short segments so halts do not end the run early.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0,
              16'($urandom));
      end
    end

    // Stall counter saturates instead of wrapping.
    do_reset();
    for (int i = 0; i < 65541; i++) cycle(1, 0, 0, 0, 16'($urandom));
    chk("t5_sat", stallCount, 32'hFFFF);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    cycle(0, 0, 0, 1, 16'hCAFE);
    cycle(0, 0, 0, 0, 16'h0);
    chk("t6_draining", state, 32'd1);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check_comb();
    check_regs();
    #3 rst = 1'b0;
    #1;
    check_regs();
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 16'h2468);
    chk("t6_run", ctrl_ex, 32'h2468);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
